adder_mult_seq: RTL and testbench



---
 rtl/adder_mult_seq.sv | 68 ++++++
 tb/tb_adder_mult_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/adder_mult_seq.sv
// adder_mult_seq: shift-add multiplier controller driving a shared external ripple-carry adder
module adder_mult_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_cout,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   mcand, acc, q;
    logic [CW-1:0]      cnt;
    logic               load, last;
    logic [2*WIDTH:0]   wide;
    logic [2*WIDTH-1:0] shifted;

    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;

    // next state, adder drive and status; the carry enters the MSB as the pair shifts right
    always_comb begin
        load    = (state == IDLE || state == DONE) && start;
        last    = (state == RUN) && (cnt == LAST);
        state_n = load ? RUN : (state == DONE) ? IDLE : last ? DONE : state;
        add_a   = (state == RUN) ? acc : '0;
        add_b   = (state == RUN && q[0]) ? mcand : '0;
        add_cin = 1'b0;
        busy    = (state == RUN);
        done    = (state == DONE);
        wide    = {add_cout, add_sum, q};
        shifted = wide[2*WIDTH:1];
    end

    // operand capture, accumulate-and-shift iterations and result latch
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            mcand   <= '0;
            acc     <= '0;
            q       <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (load) begin
            mcand <= a;
            q     <= b;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            {acc, q} <= shifted;
            cnt      <= cnt + CW'(1);
            if (last) product <= shifted;
        end
endmodule

// File: tb/tb_adder_mult_seq.sv
// tb_adder_mult_seq: vector, corner-sequence and random checks of adder_mult_seq against arithmetic expectations
module tb_adder_mult_seq;
    localparam int W = 4;

    logic           clk = 0, reset = 0, start = 0;
    logic [W-1:0]   a = '0, b = '0;
    logic [W-1:0]   add_a, add_b, add_sum;
    logic           add_cin, add_cout, busy, done;
    logic [2*W-1:0] product;

    int tests = 0, fails = 0;
    logic [2*W-1:0] prev_p = '0;

    typedef struct {
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs[6];

    adder_mult_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .busy(busy), .done(done), .product(product)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // launch one multiply and check every RUN cycle, latency, result and hold
    task automatic mul_check(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] expp);
        int lat;
        bit seen;
        int part;
        @(negedge clk);
        a = x; b = y; start = 1;
        @(negedge clk);
        start = 0; a = W'($urandom); b = W'($urandom);
        lat = 0; seen = 0;
        for (int k = 0; k < 3 * W && !seen; k++) begin
            if (done) seen = 1;
            else begin
                if (k < W) begin
                    part = (int'(x) * (int'(y) & ((1 << k) - 1))) >> k;
                    chk("busy_run", busy, 1);
                    chk("add_a_run", add_a, part & ((1 << W) - 1));
                    chk("add_b_run", add_b, y[k] ? x : '0);
                    chk("product_mid", product, prev_p);
                end
                lat++;
                @(negedge clk);
            end
        end
        chk("done_seen", seen, 1);
        chk("latency", lat, W);
        chk("product", product, expp);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
        chk("product_held", product, expp);
        prev_p = expp;
    endtask

    initial begin
        int dcnt;
        vecs[0] = '{4'h7, 4'h9, 8'h3F};
        vecs[1] = '{4'hF, 4'hF, 8'hE1};
        vecs[2] = '{4'h0, 4'hF, 8'h00};
        vecs[3] = '{4'hA, 4'h1, 8'h0A};
        vecs[4] = '{4'h1, 4'hF, 8'h0F};
        vecs[5] = '{4'hC, 4'h6, 8'h48};

        #3 reset = 1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_product", product, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_add_cin", add_cin, 0);
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_product", product, 0);
        end

        foreach (vecs[i]) mul_check(vecs[i].x, vecs[i].y, vecs[i].p);

        // start during RUN is ignored
        @(negedge clk);
        a = 4'h3; b = 4'h5; start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        a = 4'hF; b = 4'hF; start = 1;
        @(negedge clk);
        start = 0;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("busy_start_done_cnt", dcnt, 1);
        chk("busy_start_product", product, 8'h0F);
        prev_p = 8'h0F;

        // back-to-back launch straight from DONE
        @(negedge clk);
        a = 4'h2; b = 4'h3; start = 1;
        @(negedge clk);
        repeat (W) @(negedge clk);
        chk("b2b_done1", done, 1);
        chk("b2b_product1", product, 8'h06);
        a = 4'h4;
        @(negedge clk);
        chk("b2b_relaunch_busy", busy, 1);
        chk("b2b_relaunch_done", done, 0);
        chk("b2b_product_hold", product, 8'h06);
        start = 0;
        repeat (W) @(negedge clk);
        chk("b2b_done2", done, 1);
        chk("b2b_product2", product, 8'h0C);
        @(negedge clk);
        chk("b2b_done2_end", done, 0);
        prev_p = 8'h0C;

        // asynchronous reset mid-RUN discards the operation
        @(negedge clk);
        a = 4'hF; b = 4'hF; start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        #2 reset = 1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_product", product, 0);
        chk("midrst_add_a", add_a, 0);
        chk("midrst_add_b", add_b, 0);
        @(negedge clk);
        reset = 0;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("midrst_no_activity", dcnt, 0);
        chk("midrst_product_after", product, 0);
        prev_p = '0;
        mul_check(4'h2, 4'h2, 8'h04);

        // random operands against plain multiplication
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] x, y;
            x = W'($urandom);
            y = W'($urandom);
            mul_check(x, y, (2*W)'(x) * (2*W)'(y));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
